// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with load extraction and stall hold buffer
//
// Purpose: registers the execute-to-memory bus, takes the data-SRAM read data that
// arrives in the first cycle an instruction sits here, extracts/extends byte,
// halfword or word loads, and drives the write-back and register-file forwarding
// buses. A one-entry hold buffer keeps returned load data stable while stalled.
//
// Ports:
//   clk             in   1    pipeline clock, rising edge
//   resetn          in   1    asynchronous active-low reset
//   stall           in   6    stall vector; bit 3 = this stage, bit 4 = downstream
//   ex_to_mem_bus   in   145  {mem_op, hi_we, hi, lo_we, lo, pc, data_ram_en,
//                              data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   data_sram_rdata in   32   synchronous SRAM read data
//   mem_to_wb_bus   out  136  {hilo, pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_rf_bus   out  104  {hilo, rf_we, rf_waddr, rf_wdata}

module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic [5:0]   stall,
  input  logic [144:0] ex_to_mem_bus,
  input  logic [31:0]  data_sram_rdata,
  output logic [135:0] mem_to_wb_bus,
  output logic [103:0] mem_to_rf_bus
);

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [144:0] r_q, r_d;
  logic [31:0]  rdata_buf_q, rdata_buf_d;
  logic         buf_valid_q, buf_valid_d;

  // Only bits 3 and 4 of the stall vector concern this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // Fields of the stage register
  logic [2:0]  mem_op;
  logic [65:0] hilo;
  logic [31:0] pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;

  assign mem_op       = r_q[144:142];
  assign hilo         = r_q[141:76];
  assign pc           = r_q[75:44];
  assign data_ram_en  = r_q[43];
  assign data_ram_wen = r_q[42:39];
  assign sel_rf_res   = r_q[38];
  assign rf_we        = r_q[37];
  assign rf_waddr     = r_q[36:32];
  assign ex_result    = r_q[31:0];

  logic is_load;
  assign is_load = data_ram_en & (data_ram_wen == 4'b0000) & sel_rf_res;

  logic take_new, take_bubble;
  assign take_new    = ~stall[3];
  assign take_bubble = stall[3] & ~stall[4];

  always_comb begin
    r_d         = r_q;
    rdata_buf_d = rdata_buf_q;
    buf_valid_d = buf_valid_q;
    if (take_new) begin
      r_d = ex_to_mem_bus;
    end else if (take_bubble) begin
      r_d = '0;
    end
    // A new occupant (instruction or bubble) always invalidates the buffer,
    // so it takes priority over a capture on the same edge.
    if (take_new || take_bubble) begin
      buf_valid_d = 1'b0;
    end else if (is_load && !buf_valid_q) begin
      rdata_buf_d = data_sram_rdata;
      buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q         <= '0;
      rdata_buf_q <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      r_q         <= r_d;
      rdata_buf_q <= rdata_buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Load extraction: SRAM data is only valid in the first cycle, after that the
  // buffered copy is the source of truth.
  logic [31:0] d;
  logic [31:0] shifted;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign d         = buf_valid_q ? rdata_buf_q : data_sram_rdata;
  assign shifted   = d >> {ex_result[1:0], 3'b000};
  assign load_byte = shifted[7:0];
  assign load_half = ex_result[1] ? d[31:16] : d[15:0];

  always_comb begin
    load_data = d;
    case (mem_op)
      OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {24'h0, load_byte};
      OP_LH:   load_data = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_data = {16'h0, load_half};
      default: load_data = d;
    endcase
  end

  logic [31:0] rf_wdata;
  assign rf_wdata = sel_rf_res ? load_data : ex_result;

  assign mem_to_wb_bus = {hilo, pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {hilo, rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage

module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic [5:0]   stall;
  logic [144:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [103:0] mem_to_rf_bus;

  int n_checks;
  int n_fail;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [144:0] mk(
    input logic [2:0]  op,
    input logic        hi_we,
    input logic [31:0] hi,
    input logic        lo_we,
    input logic [31:0] lo,
    input logic [31:0] pc,
    input logic        en,
    input logic [3:0]  wen,
    input logic        sel,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] res
  );
    return {op, hi_we, hi, lo_we, lo, pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [144:0] mk_load(input logic [2:0] op, input logic [4:0] wa,
                                           input logic [31:0] addr);
    return mk(op, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_2000, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t lv[8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn          = 1'b0;
    stall           = 6'b0;
    ex_to_mem_bus   = '0;
    data_sram_rdata = 32'h0;

    lv[0] = '{"lb_a1",   3'b001, 32'h0000_1001, 32'h0000_007F};
    lv[1] = '{"lb_a3",   3'b001, 32'h0000_1003, 32'hFFFF_FF80};
    lv[2] = '{"lbu_a2",  3'b010, 32'h0000_1002, 32'h0000_00FF};
    lv[3] = '{"lh_a2",   3'b011, 32'h0000_1002, 32'hFFFF_80FF};
    lv[4] = '{"lhu_a0",  3'b100, 32'h0000_1000, 32'h0000_7F01};
    lv[5] = '{"lw",      3'b000, 32'h0000_1000, 32'h80FF_7F01};
    lv[6] = '{"lh_a3",   3'b011, 32'h0000_1003, 32'hFFFF_80FF};
    lv[7] = '{"rsvd_op", 3'b111, 32'h0000_1001, 32'h80FF_7F01};

    // Reset state
    step();
    step();
    check("reset_wb", mem_to_wb_bus, 136'h0);
    check("reset_rf", mem_to_rf_bus, 104'h0);
    resetn = 1'b1;

    // ALU pass-through
    ex_to_mem_bus = mk(3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0100, 1'b0, 4'h0,
                       1'b0, 1'b1, 5'd5, 32'h1234_5678);
    step();
    check("alu_wb_wdata", mem_to_wb_bus[31:0], 32'h1234_5678);
    check("alu_wb_waddr", mem_to_wb_bus[36:32], 5'd5);
    check("alu_wb_we", mem_to_wb_bus[37], 1'b1);
    check("alu_wb_pc", mem_to_wb_bus[69:38], 32'h0000_0100);
    check("alu_rf_wdata", mem_to_rf_bus[31:0], 32'h1234_5678);
    check("alu_rf_waddr", mem_to_rf_bus[36:32], 5'd5);

    // Load extraction
    data_sram_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 8; i++) begin
      ex_to_mem_bus = mk_load(lv[i].op, 5'd7, lv[i].addr);
      step();
      check(lv[i].tag, mem_to_wb_bus[31:0], lv[i].exp);
      check({lv[i].tag, "_rf"}, mem_to_rf_bus[31:0], lv[i].exp);
    end

    // Stall hold: data captured at first stalled edge, SRAM then changes
    ex_to_mem_bus   = mk_load(3'b000, 5'd9, 32'h0000_3000);
    data_sram_rdata = 32'hDEAD_BEEF;
    step();
    check("hold_c0", mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
    stall         = 6'b011000;
    ex_to_mem_bus = mk(3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0,
                       1'b0, 1'b1, 5'd3, 32'h0BAD_0BAD);
    step();
    data_sram_rdata = 32'h0;
    #1;
    check("hold_c1", mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
    check("hold_c1_waddr", mem_to_wb_bus[36:32], 5'd9);
    step();
    check("hold_c2", mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
    step();
    check("hold_c3", mem_to_rf_bus[31:0], 32'hDEAD_BEEF);

    // Release: new load must use fresh SRAM data, buffer invalid
    stall           = 6'b0;
    ex_to_mem_bus   = mk_load(3'b000, 5'd10, 32'h0000_3004);
    data_sram_rdata = 32'h1122_3344;
    step();
    check("release_wdata", mem_to_wb_bus[31:0], 32'h1122_3344);
    check("release_bufv", dut.buf_valid_q, 1'b0);

    // Bubble: first let the load capture into the buffer, then insert a bubble
    stall = 6'b011000;
    step();
    check("bubble_pre_bufv", dut.buf_valid_q, 1'b1);
    stall = 6'b001000;
    step();
    check("bubble_wb", mem_to_wb_bus, 136'h0);
    check("bubble_rf", mem_to_rf_bus, 104'h0);
    check("bubble_bufv", dut.buf_valid_q, 1'b0);

    // HILO pass-through
    stall         = 6'b0;
    ex_to_mem_bus = mk(3'b000, 1'b1, 32'hAAAA_0001, 1'b1, 32'h5555_0002, 32'h0000_0200,
                       1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("hilo_wb", mem_to_wb_bus[135:70], {1'b1, 32'hAAAA_0001, 1'b1, 32'h5555_0002});
    check("hilo_rf", mem_to_rf_bus[103:38], {1'b1, 32'hAAAA_0001, 1'b1, 32'h5555_0002});

    // Asynchronous reset mid-cycle, during a stall, with r non-zero
    ex_to_mem_bus = mk(3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0300, 1'b0, 4'h0,
                       1'b0, 1'b1, 5'd12, 32'hCAFE_F00D);
    step();
    check("pre_reset_we", mem_to_wb_bus[37], 1'b1);
    stall = 6'b011000;
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_wb", mem_to_wb_bus, 136'h0);
    check("async_reset_we", mem_to_wb_bus[37], 1'b0);
    check("async_reset_rf", mem_to_rf_bus, 104'h0);
    resetn = 1'b1;
    stall  = 6'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
